// File: rtl/dds_gen.sv
// DDS sine generator: phase accumulator, FCW switched only at phase wrap, quarter-wave LUT.
// Define DDS_AMP_EN to add an amplitude input and an extra scaling stage.
module dds_gen #(
  parameter int                 PHASE_W = 32,
  parameter int                 LUT_AW  = 8,
  parameter int                 DATA_W  = 8,
  parameter int                 DIV     = 4,
  parameter logic [PHASE_W-1:0] FCW_RST = 214748
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en,
  input  logic [PHASE_W-1:0]   fcw_in,
  input  logic                 fcw_load,
  input  logic [LUT_AW-1:0]    phase_ofs,
`ifdef DDS_AMP_EN
  input  logic [DATA_W-1:0]    amp,
`endif
  output logic                 fcw_busy,
  output logic [DATA_W-1:0]    sample_out,
  output logic                 sample_vld,
  output logic                 cycle_start
);
  localparam int Q     = 2 ** (LUT_AW - 2);
  localparam int IW    = LUT_AW - 2;
  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [DATA_W-1:0] MID = {1'b1, {(DATA_W-1){1'b0}}};
`ifdef DDS_AMP_EN
  localparam int STAGES = 4;
`else
  localparam int STAGES = 3;
`endif

  // Elaboration-time sine (Taylor series) so the table follows DATA_W/LUT_AW.
  function automatic int rom_val(input int i);
    real x, t, s;
    x = 3.14159265358979323846 / 2.0 * (real'(i) + 0.5) / real'(Q);
    s = 0.0;
    t = x;
    for (int k = 1; k < 24; k += 2) begin
      s = s + t;
      t = -t * x * x / real'((k + 1) * (k + 2));
    end
    return int'(real'(2 ** (DATA_W - 1) - 1) * s);
  endfunction

  logic [Q-1:0][DATA_W-2:0] w_rom;
  for (genvar g = 0; g < Q; g++) begin : g_rom
    localparam int V = rom_val(g);
    assign w_rom[g] = (DATA_W-1)'(V);
  end

  logic [CNT_W-1:0]   r_cnt;
  logic               w_tick;
  logic [PHASE_W-1:0] r_acc, w_sum, r_fcw_act, r_pend;
  logic               w_carry, r_busy, w_apply;
  logic [STAGES:0]    r_vld_pipe, r_cy_pipe;
  logic [LUT_AW-1:0]  w_addr;
  logic [IW-1:0]      w_idx, r_idx;
  logic               r_neg1, r_neg2;
  logic [DATA_W-2:0]  r_rom, w_mag;
  logic               w_neg, w_out_en;
  logic [DATA_W-1:0]  r_sample;

  assign w_tick           = en & (r_cnt == CNT_W'(DIV - 1));
  assign {w_carry, w_sum} = {1'b0, r_acc} + {1'b0, r_fcw_act};
  // Pending word waits for a wrap while running; when stopped there is no wrap to wait for.
  assign w_apply          = r_busy & ((w_tick & w_carry) | ~en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_acc     <= '0;
      r_fcw_act <= FCW_RST;
      r_pend    <= '0;
      r_busy    <= 1'b0;
    end else begin
      if (en) r_cnt <= (r_cnt == CNT_W'(DIV - 1)) ? '0 : r_cnt + 1'b1;
      else    r_cnt <= '0;
      if (w_tick)   r_acc     <= w_sum;
      if (w_apply)  r_fcw_act <= r_pend;
      if (fcw_load) r_pend    <= fcw_in;
      r_busy <= fcw_load | (r_busy & ~w_apply);
    end
  end

  assign w_addr = r_acc[PHASE_W-1 -: LUT_AW] + phase_ofs;
  assign w_idx  = w_addr[IW-1:0] ^ {IW{w_addr[LUT_AW-2]}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_pipe <= '0;
      r_cy_pipe  <= '0;
      r_idx      <= '0;
      r_neg1     <= 1'b0;
      r_neg2     <= 1'b0;
      r_rom      <= '0;
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:0], w_tick};
      r_cy_pipe  <= {r_cy_pipe[STAGES-1:0], w_tick & w_carry};
      if (r_vld_pipe[0]) begin
        r_idx  <= w_idx;
        r_neg1 <= w_addr[LUT_AW-1];
      end
      if (r_vld_pipe[1]) begin
        r_rom  <= w_rom[r_idx];
        r_neg2 <= r_neg1;
      end
    end
  end

`ifdef DDS_AMP_EN
  logic [2*DATA_W-2:0] w_prod;
  logic [DATA_W-2:0]   r_mag;
  logic                r_neg3;
  assign w_prod = r_rom * amp;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mag  <= '0;
      r_neg3 <= 1'b0;
    end else if (r_vld_pipe[2]) begin
      r_mag  <= (DATA_W-1)'(w_prod >> DATA_W);
      r_neg3 <= r_neg2;
    end
  end
  assign w_mag    = r_mag;
  assign w_neg    = r_neg3;
  assign w_out_en = r_vld_pipe[3];
`else
  assign w_mag    = r_rom;
  assign w_neg    = r_neg2;
  assign w_out_en = r_vld_pipe[2];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_sample <= MID;
    else if (w_out_en) r_sample <= w_neg ? MID - {1'b0, w_mag} : MID + {1'b0, w_mag};
  end

  assign sample_out  = r_sample;
  assign sample_vld  = r_vld_pipe[STAGES];
  assign cycle_start = r_cy_pipe[STAGES];
  assign fcw_busy    = r_busy;
endmodule

// File: tb/tb_dds_gen.sv
// Bench for dds_gen: spec-level phase/sine model with per-cycle compare plus directed literal checks.
module tb_dds_gen;
  localparam int DIV = 4;
`ifdef DDS_AMP_EN
  localparam int LAT = 4, AMPV = 128;
`else
  localparam int LAT = 3, AMPV = 256;
`endif
  // Hand-computed table points: rom[0]=2, rom[1]=5, rom[63]=127.
  localparam int E_A0 = 128 + ((2 * AMPV) >> 8);
  localparam int E_A1 = 128 + ((5 * AMPV) >> 8);
  localparam int E_PK = 128 + ((127 * AMPV) >> 8);
  localparam int E_TR = 128 - ((127 * AMPV) >> 8);
  localparam real PI = 3.14159265358979323846;

  logic clk = 1'b0, rst_n, en, fcw_load;
  logic [31:0] fcw_in;
  logic [7:0]  phase_ofs, sample_out;
  logic fcw_busy, sample_vld, cycle_start;
`ifdef DDS_AMP_EN
  logic [7:0] amp;
  initial amp = 8'd128;
`endif

  dds_gen #(.PHASE_W(32), .LUT_AW(8), .DATA_W(8), .DIV(DIV), .FCW_RST(32'd214748)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .fcw_in(fcw_in), .fcw_load(fcw_load),
    .phase_ofs(phase_ofs),
`ifdef DDS_AMP_EN
    .amp(amp),
`endif
    .fcw_busy(fcw_busy), .sample_out(sample_out), .sample_vld(sample_vld),
    .cycle_start(cycle_start));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sample for an 8-bit phase address straight from the sine, sign and magnitude rounding.
  function automatic int exp_sample(input int addr);
    real s, a;
    int  r;
    s = $sin(2.0 * PI * (real'(addr) + 0.5) / 256.0);
    a = (s < 0.0) ? -s : s;
    r = $rtoi(127.0 * a + 0.5);
    r = (r * AMPV) >> 8;
    return (s >= 0.0) ? 128 + r : 128 - r;
  endfunction

  typedef struct { int due; int val; bit cs; } exp_t;
  exp_t   expq[$];
  int     cyc = 0;
  longint m_acc, m_act, m_pend, sum;
  bit     m_busy, s1_v, s1_cy, tick, carry;
  int     m_cnt, s1_top;

  // Model: advances on every clk edge from the input values.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      m_acc = 0; m_act = 214748; m_pend = 0; m_busy = 0; m_cnt = 0; s1_v = 0;
      expq.delete();
    end else begin
      if (s1_v) begin
        expq.push_back('{cyc + LAT - 1, exp_sample((s1_top + int'(phase_ofs)) % 256), s1_cy});
        s1_v = 0;
      end
      tick  = en && (m_cnt == DIV - 1);
      carry = 0;
      if (tick) begin
        sum    = m_acc + m_act;
        carry  = (sum >> 32) != 0;
        m_acc  = sum & 64'hFFFF_FFFF;
        s1_v   = 1;
        s1_top = int'(m_acc >> 24);
        s1_cy  = carry;
      end
      if (m_busy && ((tick && carry) || !en)) begin
        m_act  = m_pend;
        m_busy = 0;
      end
      if (fcw_load) begin
        m_pend = longint'(fcw_in);
        m_busy = 1;
      end
      m_cnt = en ? ((m_cnt == DIV - 1) ? 0 : m_cnt + 1) : 0;
    end
  end

  int samp_v[$], samp_t[$];
  bit samp_cs[$];
  int last_out = 128;
  exp_t e;

  // Compare on the falling edge, plus a record of every strobe for the directed checks.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_sample", sample_out, 128);
      chk("rst_vld", sample_vld, 0);
      chk("rst_cstart", cycle_start, 0);
      chk("rst_busy", fcw_busy, 0);
      last_out = 128;
    end else begin
      if (expq.size() > 0 && expq[0].due == cyc) begin
        e = expq.pop_front();
        chk("vld", sample_vld, 1);
        chk("sample", sample_out, e.val);
        chk("cstart", cycle_start, e.cs);
        last_out = e.val;
      end else begin
        chk("vld_idle", sample_vld, 0);
        chk("hold", sample_out, last_out);
        chk("cstart_idle", cycle_start, 0);
      end
      chk("busy", fcw_busy, m_busy);
    end
    if (sample_vld) begin
      samp_v.push_back(int'(sample_out));
      samp_cs.push_back(cycle_start);
      samp_t.push_back(cyc);
    end
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic load(input logic [31:0] v);
    fcw_in = v; fcw_load = 1'b1;
    step(1);
    fcw_load = 1'b0;
  endtask

  function automatic int last_v();
    return (samp_v.size() > 0) ? samp_v[samp_v.size() - 1] : -1;
  endfunction

  int base, n0, n1, n2, ncs;
  int csi[$];

  initial begin
    rst_n = 1'b0; en = 1'b0; fcw_load = 1'b0; fcw_in = '0; phase_ofs = '0;
    step(3);
    chk("reset_out", sample_out, 128);
    chk("reset_busy", fcw_busy, 0);
    rst_n = 1'b1;
    n0 = samp_v.size();
    step(100);
    chk("idle_no_vld", samp_v.size() - n0, 0);

    // FCW=0 pins the phase at 0; offset alone picks the peak and trough.
    load(32'h0); step(1);
    phase_ofs = 8'd64; en = 1'b1;
    step(40);
    chk("peak", last_v(), E_PK);
    phase_ofs = 8'd192;
    step(40);
    chk("trough", last_v(), E_TR);
    en = 1'b0; phase_ofs = 8'd0;
    step(8);

    // One LUT address per sample.
    load(32'h0100_0000); step(1);
    chk("busy_applied_idle", fcw_busy, 0);
    en = 1'b1; base = samp_v.size();
    step(4 * 260 + 4);
    chk("first_sample", samp_v[base], E_A1);
    chk("first_cs", samp_cs[base], 0);
    chk("period_clks", samp_t[base + 1] - samp_t[base], DIV);
    chk("wrap_sample", samp_v[base + 255], E_A0);
    chk("wrap_cs", samp_cs[base + 255], 1);
    ncs = 0;
    for (int i = base; i < base + 260; i++) ncs += samp_cs[i];
    chk("cs_count_256", ncs, 1);

    // Mid-period FCW change waits for the wrap, then halves the period.
    load(32'h0200_0000);
    step(200);
    chk("busy_hold", fcw_busy, 1);
    base = samp_v.size();
    step(4 * 520);
    chk("busy_clear", fcw_busy, 0);
    for (int i = base; i < samp_v.size(); i++) if (samp_cs[i]) csi.push_back(i);
    chk("cs_seen", csi.size() >= 3, 1);
    if (csi.size() >= 3) begin
      chk("new_period_a", csi[1] - csi[0], 128);
      chk("new_period_b", csi[2] - csi[1], 128);
    end

    // Drop enable mid-stream, then resume from the held phase.
    step(5);
    en = 1'b0; n0 = samp_v.size();
    step(4); n1 = samp_v.size();
    step(20); n2 = samp_v.size();
    chk("drain_max1", n1 - n0 <= 1, 1);
    chk("silence", n2 - n1, 0);
    en = 1'b1;
    step(40);

    // Reset with a word pending: the pending word is lost, FCW_RST is active again.
    load(32'h0300_0000);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out", sample_out, 128);
    chk("async_rst_vld", sample_vld, 0);
    chk("async_rst_busy", fcw_busy, 0);
    step(2);
    rst_n = 1'b1; phase_ofs = 8'd0; base = samp_v.size();
    step(4 * 80 + 4);
    chk("fcw_rst_addr0", samp_v[base + 77], E_A0);
    chk("fcw_rst_cs", samp_cs[base + 77], 0);
    chk("fcw_rst_addr1", samp_v[base + 78], E_A1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
